// File: rtl/test_status_pkg.sv
// Shared definitions for the test-status transmitter.
// Holds the register offsets (word index from wb_adr_i[3:2]), the strobe FSM state
// encoding, the STATUS bit positions and the counter-load helper.
package test_status_pkg;

  // Register word indices
  localparam logic [1:0] RegConfig   = 2'd0;
  localparam logic [1:0] RegPush     = 2'd1;
  localparam logic [1:0] RegStatus   = 2'd2;
  localparam logic [1:0] RegCounters = 2'd3;

  // STATUS bit positions; the fifo count occupies [StatusCountMsb:0]
  localparam int unsigned StatusCountMsb = 4;
  localparam int unsigned StatusFull     = 5;
  localparam int unsigned StatusEmpty    = 6;
  localparam int unsigned StatusBusy     = 7;
  localparam int unsigned StatusOverflow = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StGap
  } state_e;

  // Down-counter load value for a phase lasting max(cycles,1) cycles; the phase
  // ends in the cycle where the counter reads zero.
  function automatic logic [7:0] load_count(input logic [7:0] cycles);
    return (cycles == 8'd0) ? 8'd0 : cycles - 8'd1;
  endfunction

endpackage

// File: rtl/test_status_fifo.sv
// Synchronous 1-bit result FIFO with show-ahead read data.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (empties the queue)
//   push, push_data     enqueue request and its bit
//   pop                 dequeue request (ignored when empty)
//   pop_data            bit at the head of the queue
//   count, full, empty  occupancy
//   drop                push refused because the queue is full and nothing pops
// A push while full is accepted when a pop happens in the same cycle.
module test_status_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       push_data,
  input  logic       pop,
  output logic       pop_data,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       drop
);

  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Depth-1:0] mem_q;
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [4:0]       count_q;
  logic             push_ok, pop_ok;

  assign full     = (count_q == 5'(Depth));
  assign empty    = (count_q == 5'd0);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign drop     = push & ~push_ok;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + Aw'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + Aw'(1);
      count_q <= count_q + {4'd0, push_ok} - {4'd0, pop_ok};
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/test_status_tx.sv
// Wishbone-slave test-result transmitter.
// Firmware pushes pass/fail bits; each one is presented on success_out and then
// qualified by a next_test_out pulse, with success_out stable across the pulse.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wb_cyc_i .. wb_dat_o  Wishbone slave (single-cycle registered ack)
//   success_out           result bit to GPIO
//   next_test_out         result strobe to GPIO
//   busy                  FSM active or results still queued
// Registers (word index wb_adr_i[3:2]): CONFIG, PUSH, STATUS, COUNTERS.
// Optional macro TEST_STATUS_COUNTER_EN adds saturating pass/fail counters in
// COUNTERS; without it COUNTERS reads 0 and ignores writes.
module test_status_tx
  import test_status_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  DEF_SETUP  = 4'd4,
  parameter logic [7:0]  DEF_WIDTH  = 8'd8,
  parameter logic [7:0]  DEF_GAP    = 8'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        success_out,
  output logic        next_test_out,
  output logic        busy
);

  // Bus interface
  logic        bus_req;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_word, status_word, counters_word;
  logic        wr_pend_q;
  logic [1:0]  wr_reg_q;
  logic [31:0] wr_dat_q;
  logic [3:0]  wr_sel_q;

  // Configuration and flags
  logic [3:0]  cfg_setup_q;
  logic [7:0]  cfg_width_q, cfg_gap_q;
  logic        ovf_q, ovf_d, ovf_clr;

  // FIFO
  logic        push, pop, pop_bit;
  logic [4:0]  fifo_count;
  logic        fifo_full, fifo_empty, fifo_drop;

  // FSM
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        success_q, success_d;
  logic        next_test_q, next_test_d;

  logic        unused_bits;
  assign unused_bits = ^{wb_adr_i[1:0], wr_dat_q[31:24], wr_dat_q[7:4], wr_sel_q[3]};

  // ---------------------------------------------------------------------------
  // Wishbone: ack one cycle after the request, never back to back. Writes are
  // captured with the request and take effect at the end of the ack cycle.
  // ---------------------------------------------------------------------------
  assign bus_req  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdata_q;

  always_comb begin
    status_word                     = '0;
    status_word[StatusCountMsb:0]   = fifo_count;
    status_word[StatusFull]         = fifo_full;
    status_word[StatusEmpty]        = fifo_empty;
    status_word[StatusBusy]         = busy;
    status_word[StatusOverflow]     = ovf_q;

    case (wb_adr_i[3:2])
      RegConfig:   rd_word = {8'd0, cfg_gap_q, cfg_width_q, 4'd0, cfg_setup_q};
      RegPush:     rd_word = '0;
      RegStatus:   rd_word = status_word;
      RegCounters: rd_word = counters_word;
      default:     rd_word = '0;
    endcase

    rdata_d = (bus_req && !wb_we_i) ? rd_word : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      wr_pend_q <= 1'b0;
      wr_reg_q  <= 2'd0;
      wr_dat_q  <= '0;
      wr_sel_q  <= 4'd0;
    end else begin
      ack_q     <= bus_req;
      rdata_q   <= rdata_d;
      wr_pend_q <= bus_req & wb_we_i;
      if (bus_req) begin
        wr_reg_q <= wb_adr_i[3:2];
        wr_dat_q <= wb_dat_i;
        wr_sel_q <= wb_sel_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------------
  assign push    = wr_pend_q && (wr_reg_q == RegPush) && wr_sel_q[0];
  assign ovf_clr = wr_pend_q && (wr_reg_q == RegStatus) && wr_sel_q[1] && wr_dat_q[8];
  // A dropped push outranks a clear landing in the same cycle.
  assign ovf_d   = fifo_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_setup_q <= DEF_SETUP;
      cfg_width_q <= DEF_WIDTH;
      cfg_gap_q   <= DEF_GAP;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (wr_pend_q && (wr_reg_q == RegConfig)) begin
        if (wr_sel_q[0]) cfg_setup_q <= wr_dat_q[3:0];
        if (wr_sel_q[1]) cfg_width_q <= wr_dat_q[15:8];
        if (wr_sel_q[2]) cfg_gap_q   <= wr_dat_q[23:16];
      end
    end
  end

  test_status_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_dat_q[0]),
    .pop       (pop),
    .pop_data  (pop_bit),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  // ---------------------------------------------------------------------------
  // Strobe FSM. Phase counters are loaded on entry from the current CONFIG, so a
  // CONFIG write only affects phases entered after it lands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      success_q   <= 1'b0;
      next_test_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      success_q   <= success_d;
      next_test_q <= next_test_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StSetup;
          cnt_d   = load_count({4'd0, cfg_setup_q});
        end
      end
      StSetup: begin
        if (cnt_q == 8'd0) begin
          state_d = StPulse;
          cnt_d   = load_count(cfg_width_q);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StPulse: begin
        if (cnt_q == 8'd0) begin
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHold: begin
        if (cfg_gap_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          state_d = StGap;
          cnt_d   = load_count(cfg_gap_q);
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are registered; success_out only moves when a result is popped, which
  // is always well before the next pulse.
  always_comb begin
    pop         = (state_q == StIdle) && !fifo_empty;
    success_d   = pop ? pop_bit : success_q;
    next_test_d = (state_d == StPulse);
  end

  assign success_out   = success_q;
  assign next_test_out = next_test_q;
  assign busy          = (state_q != StIdle) || !fifo_empty;

  // ---------------------------------------------------------------------------
  // Optional pass/fail counters
  // ---------------------------------------------------------------------------
`ifdef TEST_STATUS_COUNTER_EN
  logic [15:0] pass_cnt_q, fail_cnt_q;
  logic        cnt_clr, pulse_done;

  assign cnt_clr    = wr_pend_q && (wr_reg_q == RegCounters);
  assign pulse_done = (state_q == StPulse) && (cnt_q == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= 16'd0;
      fail_cnt_q <= 16'd0;
    end else if (cnt_clr) begin
      pass_cnt_q <= 16'd0;
      fail_cnt_q <= 16'd0;
    end else if (pulse_done) begin
      if (success_q) begin
        if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
      end else begin
        if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
      end
    end
  end

  assign counters_word = {fail_cnt_q, pass_cnt_q};
`else
  assign counters_word = '0;
`endif

endmodule

// File: tb/tb_test_status_tx.sv
module tb_test_status_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i, wb_adr_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o, success_out, next_test_out, busy;

  test_status_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_sel_i      (wb_sel_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_o      (wb_ack_o),
    .wb_dat_o      (wb_dat_o),
    .success_out   (success_out),
    .next_test_out (next_test_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Cycle stamp and edge recorders (sampled mid-cycle)
  int   cyc_n = 0;
  int   rise_q[$], fall_q[$], chg_q[$];
  int   bad_chg = 0;
  logic nt_prev = 1'b0, succ_prev = 1'b0;
  // success_out sampled on each rising edge of next_test_out, like an external monitor
  logic samp_q[$];
  int   pass_m = 0, fail_m = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (next_test_out && !nt_prev) rise_q.push_back(cyc_n);
    if (!next_test_out && nt_prev) fall_q.push_back(cyc_n);
    if (success_out !== succ_prev) begin
      chg_q.push_back(cyc_n);
      if (next_test_out) bad_chg <= bad_chg + 1;
    end
    nt_prev   <= next_test_out;
    succ_prev <= success_out;
  end

  always @(posedge next_test_out) begin
    samp_q.push_back(success_out);
    if (success_out) pass_m++;
    else fail_m++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd);
    bit got = 0;
    rd = '0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        rd = wb_dat_o;
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: actual=no ack required=ack within 8 cycles (adr=%h)", adr);
    end
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] dummy;
    bus(1'b1, adr, dat, sel, dummy);
  endtask

  task automatic rd(input logic [3:0] adr, output logic [31:0] data);
    bus(1'b0, adr, 32'd0, 4'hF, data);
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: actual=busy required=idle within %0d cycles", name, budget);
    end
  endtask

  // Push one result once the FIFO has room
  task automatic push_room(input logic bit_v);
    logic [31:0] st;
    bit room = 0;
    for (int i = 0; i < 40; i++) begin
      rd(4'h8, st);
      if (!st[5]) begin
        room = 1;
        break;
      end
    end
    if (!room) begin
      checks++;
      failures++;
      $display("FAIL push_room: actual=full required=room within 40 polls");
    end
    wr(4'h4, {31'd0, bit_v}, 4'h1);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] r;
    logic [2:0]  e3;
    logic [31:0] exp_cnt;
    bit          ack_seen;
    bit          nt_seen;
    int rb, fb, cb, sb, pb, fbm;

    vecs[0] = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h00080804};
    vecs[1] = '{1'b1, 4'h0, 32'hFFFFFFFF, 4'h1, 32'h0};
    vecs[2] = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h0008080F};
    vecs[3] = '{1'b1, 4'h0, 32'h00ABCD00, 4'h6, 32'h0};
    vecs[4] = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h00ABCD0F};
    vecs[5] = '{1'b1, 4'h0, 32'h00080804, 4'hF, 32'h0};
    vecs[6] = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h00080804};
    vecs[7] = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h0};
    vecs[8] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h00000040};
    vecs[9] = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0};

    rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 4'h0; wb_adr_i = 4'h0; wb_dat_i = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {28'd0, wb_ack_o, success_out, next_test_out, busy}, 32'd0);
    chk("reset_rdata", wb_dat_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Register map vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) begin
        wr(vecs[i].adr, vecs[i].dat, vecs[i].sel);
      end else begin
        rd(vecs[i].adr, r);
        chk($sformatf("vec%0d_rd_%h", i, vecs[i].adr), r, vecs[i].exp);
      end
    end

    // Strobe with cyc low must be ignored
    wb_cyc_i = 1'b0; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 4'h4; wb_dat_i = 32'h1; wb_sel_i = 4'hF;
    ack_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wb_ack_o) ack_seen = 1;
    end
    @(negedge clk);
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    chk("cyc_low_ack", {31'd0, ack_seen}, 32'd0);
    rd(4'h8, r);
    chk("cyc_low_status", r, 32'h40);

    // Default timing: cycle k after the ack cycle
    wr(4'h4, 32'h1, 4'h1);
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk); #1;
      e3 = {k <= 22, (k >= 6) && (k <= 13), k >= 2};
      chk($sformatf("t1_cyc%0d_busy_nt_succ", k),
          {29'd0, busy, next_test_out, success_out}, {29'd0, e3});
    end

    // Zero config: minimal pulses
    wr(4'h0, 32'h0, 4'hF);
    rb = rise_q.size(); fb = fall_q.size(); cb = chg_q.size(); sb = samp_q.size();
    pb = bad_chg;
    wr(4'h4, 32'h0, 4'h1);
    wr(4'h4, 32'h1, 4'h1);
    wait_idle(60, "t2_idle");
    repeat (2) @(negedge clk);
    chk("t2_rises", rise_q.size() - rb, 2);
    chk("t2_falls", fall_q.size() - fb, 2);
    chk("t2_changes", chg_q.size() - cb, 2);
    chk("t2_change_during_pulse", bad_chg - pb, 0);
    if ((rise_q.size() - rb == 2) && (fall_q.size() - fb == 2) && (chg_q.size() - cb == 2)) begin
      chk("t2_setup_a", rise_q[rb] - chg_q[cb], 1);
      chk("t2_setup_b", rise_q[rb+1] - chg_q[cb+1], 1);
      chk("t2_width", fall_q[fb] - rise_q[rb], 1);
      chk("t2_fall_to_rise", rise_q[rb+1] - fall_q[fb], 3);
      chk("t2_sample_a", {31'd0, samp_q[sb]}, 32'd0);
      chk("t2_sample_b", {31'd0, samp_q[sb+1]}, 32'd1);
    end

    // Overflow while stalled in a 255-cycle gap
    wr(4'h0, 32'h00FF0000, 4'hF);
    wr(4'h4, 32'h1, 4'h1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) wr(4'h4, 32'h1, 4'h1);
    rd(4'h8, r);
    chk("t3_status_full_ovf", r, 32'h000001A4);
    wr(4'h8, 32'h00000100, 4'h2);
    rd(4'h8, r);
    chk("t3_status_ovf_cleared", r, 32'h000000A4);
    sb = samp_q.size();
    wait_idle(2000, "t3_idle");
    chk("t3_strobes", samp_q.size() - sb, 4);

    // 17 results, last one a fail
    wr(4'h0, 32'h0, 4'hF);
    sb = samp_q.size();
    for (int i = 0; i < 17; i++) push_room(i < 16);
    wait_idle(300, "t4_idle");
    chk("t4_samples", samp_q.size() - sb, 17);
    if (samp_q.size() - sb == 17) begin
      for (int i = 0; i < 17; i++)
        chk($sformatf("t4_sample%0d", i), {31'd0, samp_q[sb+i]}, (i < 16) ? 32'd1 : 32'd0);
    end

    // Counters: 3 pass, 2 fail
    wr(4'hC, 32'h0, 4'hF);
    pb = pass_m; fbm = fail_m;
    push_room(1'b1); push_room(1'b1); push_room(1'b1);
    push_room(1'b0); push_room(1'b0);
    wait_idle(300, "t6_idle");
    chk("t6_monitor_pass", pass_m - pb, 3);
    chk("t6_monitor_fail", fail_m - fbm, 2);
`ifdef TEST_STATUS_COUNTER_EN
    exp_cnt = 32'h00020003;
`else
    exp_cnt = 32'h0;
`endif
    rd(4'hC, r);
    chk("t6_counters", r, exp_cnt);
    wr(4'hC, 32'hFFFFFFFF, 4'hF);
    rd(4'hC, r);
    chk("t6_counters_cleared", r, 32'h0);

    // Asynchronous reset in the middle of a pulse
    wr(4'h0, 32'h00030201, 4'hF);
    wr(4'h4, 32'h1, 4'h1);
    wr(4'h4, 32'h0, 4'h1);
    nt_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (next_test_out) begin
        nt_seen = 1;
        break;
      end
    end
    chk("t5_pulse_seen", {31'd0, nt_seen}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_drop", {29'd0, next_test_out, success_out, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb = samp_q.size();
    rd(4'h8, r);
    chk("t5_status_empty", r, 32'h40);
    rd(4'h0, r);
    chk("t5_config_default", r, 32'h00080804);
    rd(4'hC, r);
    chk("t5_counters_zero", r, 32'h0);
    repeat (20) @(negedge clk);
    chk("t5_no_strobe_after_reset", samp_q.size() - sb, 0);
    chk("t5_outputs_idle", {29'd0, next_test_out, success_out, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
